// File: rtl/hs_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_send_arbiter
// Purpose  : Round-robin arbiter sharing one toggle-request handshake sender
//            among NREQ source-domain requesters. The winner's word is latched
//            into adata, issued with a single asend strobe, and the channel is
//            held until the sender reports aready again. The winner then gets
//            a req_done pulse and priority rotates past it.
// Ports    : aclk, arst         clock, asynchronous active-high reset
//            req_valid/req_data per-requester request and packed payloads
//            req_ready          one-hot pulse, word taken (first SEND cycle)
//            req_done           one-hot pulse, far side acknowledged
//            adata/asend        registered word and send strobe to the sender
//            aready             sender idle (1) / transfer in flight (0)
//            busy, grant_id     SEND/WAIT indicator, current/last winner
// Options  : HS_ARB_SRCID_EN    when defined, adata = {grant_id, payload}
// Revision : 1.0 - initial release
// ============================================================================
module hs_send_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int WIDTH_D = 8,
    localparam int IDW     = $clog2(NREQ),
`ifdef HS_ARB_SRCID_EN
    localparam int ADATA_W = WIDTH_D + IDW
`else
    localparam int ADATA_W = WIDTH_D
`endif
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH_D-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           req_done,
    output logic [ADATA_W-1:0]        adata,
    output logic                      asend,
    input  logic                      aready,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id
);

    localparam logic [1:0]     c_ST_IDLE = 2'd0;
    localparam logic [1:0]     c_ST_SEND = 2'd1;
    localparam logic [1:0]     c_ST_WAIT = 2'd2;
    localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] c_ONE_ID  = IDW'(1);
    localparam logic [NREQ-1:0] c_OH_ONE = NREQ'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant_id;
    logic [ADATA_W-1:0] r_adata;
    logic               r_asend;
    logic               r_first;      // high only in the first SEND cycle
    logic               w_grant;      // IDLE -> SEND this edge
    logic               w_complete;   // WAIT -> IDLE this edge
    logic               w_found;
    logic [IDW-1:0]     w_cand;
    logic [IDW-1:0]     w_win;
    logic [WIDTH_D-1:0] w_payload;
    logic [ADATA_W-1:0] w_adata_nxt;
    logic [NREQ-1:0]    w_grant_oh;

    // Rotating priority search: first set bit at or above r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IDW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Payload mux for the winning lane.
    always_comb begin
        w_payload = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win == IDW'(j)) begin
                w_payload = req_data[j*WIDTH_D +: WIDTH_D];
            end
        end
    end

`ifdef HS_ARB_SRCID_EN
    assign w_adata_nxt = {w_win, w_payload};
`else
    assign w_adata_nxt = w_payload;
`endif

    // Next-state decode. A SEND with aready low is only a safety net: the
    // sender is known idle at grant time, so it normally accepts at once.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (aready && w_found) begin
                    w_state_nxt = c_ST_SEND;
                    w_grant     = 1'b1;
                end
            end
            c_ST_SEND: begin
                if (aready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (aready) begin
                    w_state_nxt = c_ST_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state    <= c_ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_adata    <= '0;
            r_asend    <= 1'b0;
            r_first    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= w_grant;
            r_asend <= (w_state_nxt == c_ST_SEND);
            if (w_grant) begin
                r_grant_id <= w_win;
                r_adata    <= w_adata_nxt;
            end
            if (w_complete) begin
                r_rr_ptr <= (r_grant_id == c_LAST_ID) ? '0 : (r_grant_id + c_ONE_ID);
            end
        end
    end

    assign w_grant_oh = c_OH_ONE << r_grant_id;

    assign req_ready = r_first ? w_grant_oh : '0;
    // The acknowledge is reported in the same cycle the sender goes idle, so
    // this path is combinational from aready.
    assign req_done  = ((r_state == c_ST_WAIT) && aready) ? w_grant_oh : '0;
    assign adata     = r_adata;
    assign asend     = r_asend;
    assign busy      = (r_state != c_ST_IDLE);
    assign grant_id  = r_grant_id;

endmodule
`default_nettype wire
